seq_counter_arbiter: RTL
========================

// Module: seq_counter_arbiter
// PURPOSE
// - Shares one 4-bit sequence counter (0000,0001,0011,0111,1111,1110,1100,1000, wrap) between two requesters.
// - A requester asks for N steps; the block grants the counter, advances it N codes (one per clock), then signals done.
// - Arbitration is round-robin.
// - Sits between the step-sequence counter datapath and its two client controllers; owns the counter state.
// PARAMETERS
// - STEP_W  4  width of each requester's step-count field; max request = 2**STEP_W-1 steps
// PORTS
// - clock    in   1       rising-edge clock
// - clear    in   1       asynchronous, active-low reset
// - req      in   2       req[i]=1: requester i wants the counter; hold high until done
// - steps0   in   STEP_W  step count for requester 0; sampled only at grant
// - steps1   in   STEP_W  step count for requester 1; sampled only at grant
// - grant    out  2       one-hot owner of the counter; 00 when idle
// - busy     out  1       1 in RUN or DONE
// - done     out  1       one-cycle pulse when the granted run completes
// - q        out  4       current counter code
// BEHAVIOUR
// - Reset (clear=0, async, immediate):
//   - q=0000, grant=00, busy=0, done=0, state=IDLE, rr pointer=0 (requester 0 favoured), remaining=0.
// - Sequence (next-code function):
//   - 0000->0001->0011->0111->1111->1110->1100->1000->0000.
//   - Any other code (illegal) -> 0000 on the next advance.
// - States IDLE, RUN, DONE; all transitions on the rising clock edge.
// - IDLE:
//   - No req: hold; q holds.
//   - One req: grant that requester.
//   - Both req: grant the requester the rr pointer favours.
//   - On grant: grant<=onehot, remaining<=steps of winner.
//   - Next state: RUN if steps!=0; DONE if steps==0 (no advance).
// - RUN, each edge:
//   - q<=next(q), remaining<=remaining-1.
//   - When remaining==1 at the edge: state<=DONE.
//   - Exactly N advances for a request of N.
// - DONE (one cycle):
//   - done=1, grant still asserted.
//   - Next edge: grant<=00, state<=IDLE, rr pointer<=other requester.
// - Latency: req high before edge E -> grant after E -> first advance at E+1 -> done high in the cycle after the Nth advance.
// - Abort: if req of the granted requester drops in RUN:
//   - Next edge: state<=IDLE, grant<=00, no done pulse, q holds current code.
//   - rr pointer still flips.
// - Reset mid-run: async clear overrides everything; no done pulse.
// - Minimum IDLE gap: one cycle between runs. New grants are only made from IDLE.
// - Non-granted req and steps changes during RUN are ignored.
// - remaining is STEP_W bits; never underflows (RUN is exited at 1).
// - done and grant are registered outputs; busy = (state!=IDLE).
// CONFIGURATION
// - SEQ_ARB_HOME_ON_GRANT_EN
//   - Defined: at every grant, q<=0000 on the grant edge. Each run starts from home; N steps land on the code N positions from 0000.
//   - Undefined: q continues from wherever the previous run left it.
// TESTING
// 1. Reset, req=01, steps0=3 -> grant=01; q 0001,0011,0111 on 3 edges; done 1 cycle; grant=00; q holds 0111.
// 2. req=11 both from reset, steps0=2, steps1=2 -> req0 served first (q->0011), then req1 (q->1111 without _EN; ->0011 with _EN).
// 3. req=01, steps0=0 -> grant=01, next cycle done=1, q unchanged, then IDLE.
// 4. steps0=10 from 0000 -> q wraps through 1000->0000; ends at 0011; done after exactly 10 advances.
// 5. req0 dropped after 2 advances -> IDLE next edge, no done, q=0011; later clear=0 mid-run -> q=0000, grant=00 immediately.
// 6. Force illegal q (e.g. 0101 via force) in RUN -> next advance q=0000.

Source files
------------

// File: rtl/seq_counter_arbiter.sv
// Round-robin arbiter sharing one 4-bit step-sequence counter between two requesters.
// Optional build macro SEQ_ARB_HOME_ON_GRANT_EN: return q to 0000 on every grant edge.
//
// state | meaning
// IDLE  | no owner; grants made here only
// RUN   | owner holds counter, one advance per clock
// DONE  | run complete; done pulse, grant still held
module seq_counter_arbiter #(
  parameter int STEP_W = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [1:0]        req,
  input  logic [STEP_W-1:0] steps0,
  input  logic [STEP_W-1:0] steps1,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              done,
  output logic [3:0]        q
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic              rr_ptr, rr_nxt;
  logic              owner, owner_nxt;
  logic [STEP_W-1:0] remaining, rem_nxt;
  logic [1:0]        grant_nxt;
  logic              done_nxt;
  logic [3:0]        q_nxt;
  logic              winner;
  logic [STEP_W-1:0] win_steps;

  // Illegal codes fall back to home on the next advance.
  function automatic logic [3:0] next_code(input logic [3:0] c);
    case (c)
      4'b0000: next_code = 4'b0001;
      4'b0001: next_code = 4'b0011;
      4'b0011: next_code = 4'b0111;
      4'b0111: next_code = 4'b1111;
      4'b1111: next_code = 4'b1110;
      4'b1110: next_code = 4'b1100;
      4'b1100: next_code = 4'b1000;
      default: next_code = 4'b0000;
    endcase
  endfunction

  always_comb begin
    winner    = (req == 2'b11) ? rr_ptr : req[1];
    win_steps = winner ? steps1 : steps0;
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    owner_nxt = owner;
    rem_nxt   = remaining;
    grant_nxt = grant;
    done_nxt  = 1'b0;
    q_nxt     = q;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          grant_nxt = winner ? 2'b10 : 2'b01;
          owner_nxt = winner;
          rem_nxt   = win_steps;
`ifdef SEQ_ARB_HOME_ON_GRANT_EN
          q_nxt     = 4'b0000;
`endif
          if (win_steps != '0) begin
            state_nxt = RUN;
          end else begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end
        end
      end
      RUN: begin
        // Owner dropping its request aborts the run without a done pulse.
        if (!req[owner]) begin
          state_nxt = IDLE;
          grant_nxt = 2'b00;
          rr_nxt    = ~owner;
        end else begin
          q_nxt   = next_code(q);
          rem_nxt = remaining - STEP_W'(1);
          if (remaining == STEP_W'(1)) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
        rr_nxt    = ~owner;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      owner     <= 1'b0;
      remaining <= '0;
      grant     <= 2'b00;
      done      <= 1'b0;
      q         <= 4'b0000;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      owner     <= owner_nxt;
      remaining <= rem_nxt;
      grant     <= grant_nxt;
      done      <= done_nxt;
      q         <= q_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule
